// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the registered N:1 selector: state encoding and select-width helper.
package mux_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Bits needed to encode n selects, never less than one so a 2:1 still gets a real select line.
  function automatic int clog2Min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N:1 selector; out-of-range selects give zero data and raise err_o.
module mux_sel_n
  import mux_pipe_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32,
  localparam int SEL_W = clog2Min1(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    err_o
);

  // Scan every legal input; a select that matches none of them is the error case.
  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = in_data_i[k*WIDTH +: WIDTH];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 selector with valid/ready on both sides. A main register plus one
// skid entry let in_ready be a flop while still sustaining one beat per cycle.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8,
  localparam int SEL_W    = clog2Min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  state_e               state_q, state_d;
  logic                 inReady_q;
  logic [WIDTH-1:0]     mainData_q, skidData_q;
  logic [SEL_W-1:0]     mainSel_q, skidSel_q;
  logic                 mainErr_q, skidErr_q;
  logic [ERR_CNT_W-1:0] errCnt_q;

  logic [WIDTH-1:0]     selData;
  logic                 selErr;
  logic                 accept;
  logic                 loadMainIn, loadMainSkid, loadSkid;

  mux_sel_n #(
    .NUM_IN (NUM_IN),
    .WIDTH  (WIDTH)
  ) u_sel (
    .in_data_i (in_data),
    .sel_i     (in_sel),
    .data_o    (selData),
    .err_o     (selErr)
  );

  assign accept    = in_valid & inReady_q;
  assign in_ready  = inReady_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = mainData_q;
  assign out_sel   = mainSel_q;
  assign out_err   = mainErr_q;
  assign err_count = errCnt_q;

  // State register; in_ready is derived from the next state so TWO is never entered with ready still high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      inReady_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != ST_TWO);
    end
  end

  // Occupancy transitions: accepts add a beat, output transfers remove one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (out_ready) state_d = accept ? ST_ONE : ST_EMPTY;
        else if (accept) state_d = ST_TWO;
      end
      ST_TWO: if (out_ready) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  // Steer the incoming beat into main or skid, and refill main from skid when it drains.
  always_comb begin
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state_q)
      ST_EMPTY: loadMainIn = accept;
      ST_ONE: begin
        if (out_ready) loadMainIn = accept;
        else loadSkid = accept;
      end
      ST_TWO: loadMainSkid = out_ready;
      default: ;
    endcase
  end

  // Main (output) and skid beat registers; main only changes when empty or draining, so outputs hold under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mainData_q <= '0;
      mainSel_q  <= '0;
      mainErr_q  <= 1'b0;
      skidData_q <= '0;
      skidSel_q  <= '0;
      skidErr_q  <= 1'b0;
    end else begin
      if (loadMainIn) begin
        mainData_q <= selData;
        mainSel_q  <= in_sel;
        mainErr_q  <= selErr;
      end else if (loadMainSkid) begin
        mainData_q <= skidData_q;
        mainSel_q  <= skidSel_q;
        mainErr_q  <= skidErr_q;
      end
      if (loadSkid) begin
        skidData_q <= selData;
        skidSel_q  <= in_sel;
        skidErr_q  <= selErr;
      end
    end
  end

  // Saturating count of bad selects, taken when the beat is accepted rather than when it leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errCnt_q <= '0;
    end else if (accept && selErr && (errCnt_q != '1)) begin
      errCnt_q <= errCnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: a 4-input instance for streaming/backpressure/reset
// and a 3-input instance with a 4-bit counter for error-select and saturation.
module tb_mux_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 4-input, 32-bit, 8-bit counter instance
  logic         v4 = 1'b0, r4, ov4, ordy4 = 1'b0, oe4;
  logic [1:0]   sel4 = '0, os4;
  logic [127:0] data4 = '0;
  logic [31:0]  od4;
  logic [7:0]   ec4;

  // 3-input, 32-bit, 4-bit counter instance
  logic         v3 = 1'b0, r3, ov3, ordy3 = 1'b0, oe3;
  logic [1:0]   sel3 = '0, os3;
  logic [95:0]  data3 = '0;
  logic [31:0]  od3;
  logic [3:0]   ec3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_pipe #(.NUM_IN(4), .WIDTH(32), .ERR_CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4), .in_sel(sel4), .in_data(data4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_sel(os4),
    .out_err(oe4), .err_count(ec4)
  );

  mux_pipe #(.NUM_IN(3), .WIDTH(32), .ERR_CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3), .in_sel(sel3), .in_data(data3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_sel(os3),
    .out_err(oe3), .err_count(ec3)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v4 = 1'b1; v3 = 1'b1;
    repeat (3) step();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL rst_ov4 got %0b want 0", ov4); end
    checks++; if (r4 !== 1'b0) begin errors++; $display("[TB] FAIL rst_r4 got %0b want 0", r4); end
    checks++; if (ec4 !== 8'd0) begin errors++; $display("[TB] FAIL rst_ec4 got %0d want 0", ec4); end
    checks++; if (od4 !== 32'd0) begin errors++; $display("[TB] FAIL rst_od4 got %0h want 0", od4); end
    checks++; if (ov3 !== 1'b0 || r3 !== 1'b0) begin errors++; $display("[TB] FAIL rst_dut3 got ov=%0b rdy=%0b want 0 0", ov3, r3); end
    rst_n = 1'b1;
    v4 = 1'b0; v3 = 1'b0;
    step();
    checks++; if (r4 !== 1'b1) begin errors++; $display("[TB] FAIL rel_r4 got %0b want 1", r4); end
    checks++; if (r3 !== 1'b1) begin errors++; $display("[TB] FAIL rel_r3 got %0b want 1", r3); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL rel_ov4 got %0b want 0", ov4); end
  endtask

  task automatic test_streaming();
    logic [31:0] want;
    data4 = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    ordy4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v4 = 1'b1;
      sel4 = 2'(i % 4);
      want = 32'hA000_0000 | 32'(i % 4);
      step();
      checks++; if (ov4 !== 1'b1 || od4 !== want) begin errors++; $display("[TB] FAIL stream_%0d got v=%0b d=%0h want v=1 d=%0h", i, ov4, od4, want); end
      checks++; if (os4 !== 2'(i % 4) || r4 !== 1'b1) begin errors++; $display("[TB] FAIL stream_sel_%0d got sel=%0d rdy=%0b want sel=%0d rdy=1", i, os4, r4, i % 4); end
    end
    v4 = 1'b0;
    step();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain got %0b want 0", ov4); end
  endtask

  task automatic test_backpressure();
    data4 = {32'h33, 32'h33, 32'h22, 32'h11};
    ordy4 = 1'b0;
    v4 = 1'b1; sel4 = 2'd0;
    step();
    checks++; if (od4 !== 32'h11 || r4 !== 1'b1) begin errors++; $display("[TB] FAIL bp_first got d=%0h rdy=%0b want 11 1", od4, r4); end
    sel4 = 2'd1;
    step();
    checks++; if (r4 !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_drop got %0b want 0", r4); end
    checks++; if (od4 !== 32'h11 || ov4 !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold1 got d=%0h v=%0b want 11 1", od4, ov4); end
    sel4 = 2'd2;
    step();
    checks++; if (od4 !== 32'h11 || r4 !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold2 got d=%0h rdy=%0b want 11 0", od4, r4); end
    v4 = 1'b0;
    ordy4 = 1'b1;
    step();
    checks++; if (od4 !== 32'h22 || ov4 !== 1'b1 || os4 !== 2'd1) begin errors++; $display("[TB] FAIL bp_second got d=%0h v=%0b sel=%0d want 22 1 1", od4, ov4, os4); end
    checks++; if (r4 !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back got %0b want 1", r4); end
    step();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got %0b want 0", ov4); end
  endtask

  task automatic test_error_select();
    data3 = {32'hC2, 32'hC1, 32'hC0};
    ordy3 = 1'b1;
    v3 = 1'b1; sel3 = 2'd3;
    step();
    checks++; if (od3 !== 32'd0 || oe3 !== 1'b1 || os3 !== 2'd3) begin errors++; $display("[TB] FAIL err_beat got d=%0h e=%0b sel=%0d want 0 1 3", od3, oe3, os3); end
    checks++; if (ec3 !== 4'd1) begin errors++; $display("[TB] FAIL err_count1 got %0d want 1", ec3); end
    sel3 = 2'd2;
    step();
    checks++; if (od3 !== 32'hC2 || oe3 !== 1'b0) begin errors++; $display("[TB] FAIL ok_beat got d=%0h e=%0b want c2 0", od3, oe3); end
    checks++; if (ec3 !== 4'd1) begin errors++; $display("[TB] FAIL err_count_hold got %0d want 1", ec3); end
    v3 = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    v3 = 1'b1; sel3 = 2'd3;
    for (int i = 0; i < 20; i++) begin
      want = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      step();
      checks++; if (ec3 !== want) begin errors++; $display("[TB] FAIL sat_%0d got %0d want %0d", i, ec3, want); end
    end
    v3 = 1'b0;
    step();
    checks++; if (ec3 !== 4'd15 || ov3 !== 1'b0) begin errors++; $display("[TB] FAIL sat_hold got cnt=%0d v=%0b want 15 0", ec3, ov3); end
  endtask

  task automatic test_reset_midstream();
    data4 = {32'h66, 32'h55, 32'h22, 32'h11};
    ordy4 = 1'b0;
    v4 = 1'b1; sel4 = 2'd0;
    step();
    sel4 = 2'd1;
    step();
    checks++; if (r4 !== 1'b0) begin errors++; $display("[TB] FAIL mid_in_two got rdy=%0b want 0", r4); end
    v4 = 1'b0;
    rst_n = 1'b0;
    step();
    checks++; if (ov4 !== 1'b0 || r4 !== 1'b0 || od4 !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset got v=%0b rdy=%0b d=%0h want 0 0 0", ov4, r4, od4); end
    rst_n = 1'b1;
    ordy4 = 1'b1;
    step();
    checks++; if (r4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("[TB] FAIL mid_release got rdy=%0b v=%0b want 1 0", r4, ov4); end
    v4 = 1'b1; sel4 = 2'd2;
    step();
    v4 = 1'b0;
    checks++; if (ov4 !== 1'b1 || od4 !== 32'h55) begin errors++; $display("[TB] FAIL mid_fresh got v=%0b d=%0h want 1 55", ov4, od4); end
    step();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_stale got v=%0b d=%0h want v=0", ov4, od4); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_error_select();
    test_saturation();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N-input, WIDTH-bit registered selector with a valid/ready handshake on both sides.
- Generational successor to the single-bit 2:1 combinational mux, for datapath selection points that need a pipeline register: operand select, write-back select.
- A 2-entry skid buffer gives full throughput with registered in_ready.
- Out-of-range selects are flagged per beat and counted.

Parameters:
- NUM_IN, 4, number of data inputs (2..16).
- WIDTH, 32, bits per data input.
- SEL_W, $clog2(NUM_IN) with a minimum of 1, select width (derived; do not override).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low, sampled on clk rising edge.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  registered; block can accept a beat.
- in_sel  in  SEL_W  input select for this beat.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  selected data.
- out_sel  out  SEL_W  select that produced out_data.
- out_err  out  1  beat had in_sel >= NUM_IN.
- err_count  out  ERR_CNT_W  saturating count of erroneous beats accepted.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_data=0, out_sel=0, out_err=0.
  - in_ready=0, err_count=0.
  - Skid entry cleared; FSM returns to EMPTY.
  - Reset overrides any concurrent handshake.
  - in_ready rises to 1 on the first posedge with rst_n=1.
- Handshakes:
  - Input accept occurs when in_valid & in_ready at a posedge.
  - Output transfer occurs when out_valid & out_ready at a posedge.
  - out_data, out_sel and out_err are held stable while out_valid=1 & out_ready=0.
- Select function:
  - sel < NUM_IN: data = in_data[sel*WIDTH +: WIDTH], err=0.
  - sel >= NUM_IN (only possible when NUM_IN is not a power of 2): data=0, err=1.
  - sel and err travel with the beat.
- FSM states: EMPTY (no beat held), ONE (main register valid), TWO (main and skid valid).
  - EMPTY: accept → ONE; main loads the beat.
  - ONE, with out_ready=1:
    - accept → ONE; main reloads with the new beat.
    - no accept → EMPTY.
  - ONE, with out_ready=0:
    - accept → TWO; the beat goes to skid.
    - no accept → stay ONE.
  - TWO: in_ready=0.
    - out_ready=1 → ONE; main loads from skid.
    - out_ready=0 → hold.
- in_ready is registered: 1 in EMPTY and ONE, 0 in TWO. The next-state value is computed so no beat is ever dropped.
- Latency: an accepted beat appears on out_valid the next cycle if main is free or draining.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- Ordering: strictly FIFO; skid always drains before any newer beat.
- err_count increments by 1 on each accepted beat with err=1 and saturates at 2^ERR_CNT_W-1; no wrap. Counted at input accept, not at output.
- Simultaneous accept and output transfer in ONE: the old beat leaves and the new beat enters main in the same cycle. Stays ONE.
- in_valid may drop without a handshake; no state change.
- in_sel and in_data are ignored when no accept occurs.
- Reset mid-stream: all held beats are discarded, no partial output, err_count=0.

Decomposition:
- Package mux_pipe_pkg holds:
  - the state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - a clog2-with-minimum-1 function for SEL_W.
- One combinational sub-module, mux_sel_n (params NUM_IN, WIDTH): in_data, sel → data, err. Instanced once on the input side.
- The FSM, registers and counter live in mux_pipe.

Test Plan:
- Reset/ready:
  - Hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, in_ready=0, err_count=0.
  - First cycle after release → in_ready=1.
- Streaming, NUM_IN=4, WIDTH=32, out_ready=1:
  - Send 8 beats with in_sel cycling 0..3, input k=32'hA000_000k → out_data sequence A0000000, A0000001, A0000002, A0000003 repeating.
  - Each beat appears one cycle after accept; no bubbles.
- Backpressure/skid:
  - With out_ready=0, send beats 0x11 then 0x22 → in_ready drops to 0 after the second accept.
  - out_data holds 0x11.
  - Raise out_ready → outputs 0x11 then 0x22 in order; in_ready returns to 1 one cycle after the first output transfer.
- Error select, NUM_IN=3:
  - Send in_sel=3 → out_data=0, out_err=1, out_sel=3, err_count=1.
  - Send in_sel=2 → out_err=0, err_count stays 1.
- Saturation, ERR_CNT_W=4: send 20 beats with in_sel=3 → err_count=15 and holds.
- Reset mid-operation:
  - In state TWO, assert rst_n=0 for one cycle → out_valid=0 next cycle.
  - After release, the next accepted beat emerges alone; the stale 0x11/0x22 beats never appear.
